// File: rtl/dis_frame_reader.sv
// Display readout stage: streams one QCIF 4:2:0 frame (Y, Cb, Cr) from the sync-read
// frame RAM as a valid/ready word stream with plane/line/frame framing.
module dis_frame_reader #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned Y_WPL   = 44,
  parameter int unsigned Y_LINES = 144,
  parameter int unsigned C_WPL   = 22,
  parameter int unsigned C_LINES = 72,
  parameter int unsigned CB_BASE = 6336,
  parameter int unsigned CR_BASE = 7920
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ext_frame_RAM0_cs_n,
  output logic              ext_frame_RAM0_wr,
  output logic [ADDR_W-1:0] ext_frame_RAM0_addr,
  input  logic [31:0]       ext_frame_RAM0_data,
  output logic [31:0]       pix_data,
  output logic [1:0]        pix_plane,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              frame_done
);

  // Cr plane is the same size as Cb, so the final word sits one Cb-plane past CR_BASE.
  localparam int unsigned LAST_ADDR = CR_BASE + (CR_BASE - CB_BASE) - 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic [1:0] plane;
    logic       sol;
    logic       eol;
    logic       eof;
  } side_t;

  typedef struct packed {
    logic [31:0] data;
    side_t       side;
  } entry_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          plane_q, plane_d;
  logic [5:0]          word_q, word_d;
  logic [7:0]          line_q, line_d;
  logic                infl_q, infl_d;
  side_t               infl_side_q, infl_side_d;
  entry_t              buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]          occ_q, occ_d;
  logic                done_q, done_d;

  logic                pop, issue;
  logic [5:0]          wpl_m1;
  logic [7:0]          lines_m1;
  side_t               issue_side;
  entry_t              push_e;

  assign pix_valid = (occ_q != 2'd0);
  assign pop       = pix_valid & pix_ready;

  // Credit rule: buffered + in-flight words, minus this cycle's pop, must leave room for one more.
  assign issue = (state_q == READ) &&
                 (({1'b0, occ_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop}));

  assign wpl_m1   = (plane_q == 2'd0) ? 6'(Y_WPL - 1)   : 6'(C_WPL - 1);
  assign lines_m1 = (plane_q == 2'd0) ? 8'(Y_LINES - 1) : 8'(C_LINES - 1);

  assign issue_side = '{plane: plane_q,
                        sol:   (word_q == 6'd0),
                        eol:   (word_q == wpl_m1),
                        eof:   (addr_q == ADDR_W'(LAST_ADDR))};
  assign push_e     = '{data: ext_frame_RAM0_data, side: infl_side_q};

  // NOTE: every always_comb output gets its default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    plane_d     = plane_q;
    word_d      = word_q;
    line_d      = line_q;
    infl_d      = issue;
    infl_side_d = issue ? issue_side : infl_side_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    occ_d       = occ_q;
    done_d      = pop & buf0_q.side.eof;

    unique case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        addr_d  = '0;
        plane_d = 2'd0;
        word_d  = 6'd0;
        line_d  = 8'd0;
      end
      READ: if (issue) begin
        addr_d = addr_q + 1'b1;
        if (issue_side.eof) state_d = DRAIN;
        if (word_q == wpl_m1) begin
          word_d = 6'd0;
          if (line_q == lines_m1) begin
            line_d = 8'd0;
            if (plane_q != 2'd2) plane_d = plane_q + 2'd1;
          end else begin
            line_d = line_q + 8'd1;
          end
        end else begin
          word_d = word_q + 6'd1;
        end
      end
      DRAIN: if (pop && buf0_q.side.eof) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Two-entry shift FIFO: the head is always buf0, the RAM word arriving this cycle is the push.
    unique case ({infl_q, pop})
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = push_e;
        else               buf1_d = push_e;
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = push_e;
        end else begin
          buf0_d = buf1_q;
          buf1_d = push_e;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      plane_q     <= 2'd0;
      word_q      <= 6'd0;
      line_q      <= 8'd0;
      infl_q      <= 1'b0;
      infl_side_q <= '0;
      // NOTE: the skid entries are reset because pix_data and its flags must read 0 out of reset.
      buf0_q      <= '0;
      buf1_q      <= '0;
      occ_q       <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      plane_q     <= plane_d;
      word_q      <= word_d;
      line_q      <= line_d;
      infl_q      <= infl_d;
      infl_side_q <= infl_side_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      occ_q       <= occ_d;
      done_q      <= done_d;
    end
  end

  assign ext_frame_RAM0_cs_n = ~issue;
  assign ext_frame_RAM0_wr   = 1'b0;
  assign ext_frame_RAM0_addr = addr_q;
  assign pix_data            = buf0_q.data;
  assign pix_plane           = buf0_q.side.plane;
  assign pix_sol             = buf0_q.side.sol;
  assign pix_eol             = buf0_q.side.eol;
  assign pix_eof             = buf0_q.side.eof;
  assign busy                = (state_q != IDLE);
  assign frame_done          = done_q;

endmodule

// File: tb/tb_dis_frame_reader.sv
// Self-checking bench for dis_frame_reader: a RAM model with random contents and a
// frame-layout reference model checked against the output stream every cycle.
module tb_dis_frame_reader;

  localparam int N = 9504;

  logic        clk = 1'b0;
  logic        reset, start, pix_ready;
  logic        cs_n, wr;
  logic [13:0] addr;
  logic [31:0] ram_q;
  logic [31:0] pix_data;
  logic [1:0]  pix_plane;
  logic        pix_sol, pix_eol, pix_eof, pix_valid, busy, frame_done;

  always #5 clk = ~clk;

  dis_frame_reader dut (
    .clk(clk), .reset(reset), .start(start),
    .ext_frame_RAM0_cs_n(cs_n), .ext_frame_RAM0_wr(wr),
    .ext_frame_RAM0_addr(addr), .ext_frame_RAM0_data(ram_q),
    .pix_data(pix_data), .pix_plane(pix_plane), .pix_sol(pix_sol),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .frame_done(frame_done)
  );

  logic [31:0] mem [0:N-1];

  // Sync-read RAM; garbage on non-issue cycles exposes a capture on the wrong cycle.
  always @(posedge clk) begin
    if (!cs_n && addr < N) ram_q <= mem[addr];
    else                   ram_q <= $urandom;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame layout derived directly from word index.
  function automatic logic [1:0] m_plane(input int a);
    return (a < 6336) ? 2'd0 : (a < 7920) ? 2'd1 : 2'd2;
  endfunction
  function automatic int m_wpl(input int a);
    return (a < 6336) ? 44 : 22;
  endfunction
  function automatic int m_off(input int a);
    return (a < 6336) ? a : (a < 7920) ? a - 6336 : a - 7920;
  endfunction
  function automatic logic m_sol(input int a);
    return (m_off(a) % m_wpl(a)) == 0;
  endfunction
  function automatic logic m_eol(input int a);
    return (m_off(a) % m_wpl(a)) == m_wpl(a) - 1;
  endfunction
  function automatic logic m_eof(input int a);
    return a == N - 1;
  endfunction

  int          exp_idx = 0;
  int          iss = 0, pops = 0, done_cnt = 0;
  bit          hold = 0, pend_fd = 0;
  logic [31:0] h_data;
  logic [4:0]  h_flags;

  always @(negedge clk) begin
    if (reset) begin
      exp_idx = 0; iss = 0; pops = 0; hold = 0; pend_fd = 0;
    end else begin
      check("wr_tied_low", wr, 0);
      if (!cs_n) begin
        check("issue_only_when_busy", busy, 1);
        check("issue_addr", addr, iss);
      end
      check("outstanding_le_2", (iss - pops) <= 2, 1);
      if (hold) begin
        check("hold_valid", pix_valid, 1);
        check("hold_data", pix_data, h_data);
        check("hold_flags", {pix_plane, pix_sol, pix_eol, pix_eof}, h_flags);
      end
      check("frame_done", frame_done, pend_fd);
      if (frame_done) begin
        check("done_busy_low", busy, 0);
        done_cnt++;
        iss = 0; pops = 0;
      end
      pend_fd = 0;
      if (pix_valid && pix_ready) begin
        if (exp_idx >= N) begin
          check("extra_word", 1, 0);
        end else begin
          check("word_data", pix_data, mem[exp_idx]);
          check("word_flags", {pix_plane, pix_sol, pix_eol, pix_eof},
                {m_plane(exp_idx), m_sol(exp_idx), m_eol(exp_idx), m_eof(exp_idx)});
          case (exp_idx)
            0:    check("w0_y_sol", {pix_plane, pix_sol}, 3'b001);
            43:   check("w43_eol", pix_eol, 1);
            6336: check("w6336_cb_sol", {pix_plane, pix_sol}, 3'b011);
            6357: check("w6357_cb_eol", pix_eol, 1);
            7920: check("w7920_cr_sol", {pix_plane, pix_sol}, 3'b101);
            9502: check("w9502_no_eof", pix_eof, 0);
            9503: check("w9503_eof", {pix_eol, pix_eof}, 2'b11);
            default: ;
          endcase
          pend_fd = (exp_idx == N - 1);
        end
        exp_idx++;
        pops++;
      end
      hold = pix_valid && !pix_ready;
      h_data  = pix_data;
      h_flags = {pix_plane, pix_sol, pix_eol, pix_eof};
      if (!cs_n) iss++;
    end
  end

  task automatic pulse_start();
    exp_idx = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // mode 0: ready held 1; mode 1: 50% random ready. Stops at word stop_at, or at frame_done if stop_at<0.
  task automatic run(input int mode, input int stop_at, input bit inject);
    int  d0;
    bit  ended;
    d0 = done_cnt;
    ended = 0;
    for (int c = 0; c < 30000 && !ended; c++) begin
      @(posedge clk); #1;
      pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = inject && (c == 40);
      if (stop_at >= 0) ended = (exp_idx >= stop_at);
      else              ended = (done_cnt != d0);
    end
    start = 1'b0;
    if (!ended) check("run_timeout", 0, 1);
  endtask

  initial begin
    int s0;
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    reset = 1'b1; start = 1'b0; pix_ready = 1'b1;

    check("pin_model_cb_sol", m_sol(6336 + 22), 1);
    check("pin_model_y_eol", m_eol(44 * 5 - 1), 1);
    check("pin_model_cr_plane", m_plane(7920), 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {cs_n, addr, pix_valid, pix_data, pix_plane, pix_sol, pix_eol, pix_eof, busy, frame_done},
          {1'b1, 14'd0, 1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1 reset = 1'b0;

    // First frame: latency pins, plus a start pulse while busy that must be ignored.
    pulse_start();
    @(negedge clk);
    check("lat_first_issue", {cs_n, addr, busy}, {1'b0, 14'd0, 1'b1});
    @(negedge clk);
    check("lat_valid_e2", pix_valid, 0);
    @(negedge clk);
    check("lat_valid_e3", pix_valid, 1);
    run(0, -1, 1);
    check("t1_words", exp_idx, N);
    repeat (5) @(negedge clk);
    check("idle_after_frame", {busy, cs_n}, 2'b01);

    // Random back-pressure.
    pulse_start();
    run(1, -1, 0);
    check("t4_words", exp_idx, N);

    // Long stall mid-line.
    pulse_start();
    run(0, 100, 0);
    s0 = iss;
    pix_ready = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("stall_issues_le_2", (iss - s0) <= 2, 1);
    check("stall_cs_n_high", cs_n, 1);
    #1;
    run(0, -1, 0);
    check("t5_words", exp_idx, N);

    // Mid-frame reset then a clean restart.
    pulse_start();
    run(1, 3000, 0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {pix_valid, cs_n, busy}, 3'b010);
    pix_ready = 1'b1;
    pulse_start();
    run(0, -1, 0);
    check("t6_words", exp_idx, N);
    check("done_pulses", done_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
